// File: rtl/cam_capture_win_if.sv
// DVP sensor inputs and the packed pixel stream out of the capture block.
// The sensor side is the master and the capture block is the slave. The stream has no ready, so it cannot apply backpressure.
interface cam_capture_win_if #(
    parameter int DW = 8
);
    logic              cam_vsync;
    logic              cam_href;
    logic [DW-1:0]     cam_data;
    logic              o_valid;
    logic              o_sof;
    logic              o_eol;
    logic              o_eof;
    logic [3*DW-1:0]   o_data;

    modport master (
        output cam_vsync, cam_href, cam_data,
        input  o_valid, o_sof, o_eol, o_eof, o_data
    );

    modport slave (
        input  cam_vsync, cam_href, cam_data,
        output o_valid, o_sof, o_eol, o_eof, o_data
    );
endinterface

// File: rtl/cam_capture_win.sv
// DVP camera capture: packs bytes into pixels, crops them to a window and drops a programmable number of frames.
// A pixel appears 1 clk after the edge that registers its last byte. The sensor paces the stream, so there is no backpressure.
module cam_capture_win #(
    parameter int DW = 8,
    parameter int XW = 12,
    parameter int YW = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          fmt,
    input  logic [XW-1:0]       x_start,
    input  logic [XW-1:0]       x_len,
    input  logic [YW-1:0]       y_start,
    input  logic [YW-1:0]       y_len,
    input  logic [3:0]          skip,
    cam_capture_win_if.slave    bus,
    output logic [15:0]         frame_cnt,
    output logic [1:0]          o_err
);
    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, DROP} state_t;
    state_t state, state_nxt;

    logic           vs_r, vs_d, hr_r, hr_d;
    logic [DW-1:0]  dat_r, b0, b1;
    logic [1:0]     fmt_l, ph, ph_eff, last_ph;
    logic [XW-1:0]  xs_l, xl_l, x, x_eff;
    logic [YW-1:0]  ys_l, yl_l, y;
    logic [3:0]     dcnt;
    logic           sof_pend, done;
    logic [XW:0]    x_end;
    logic [YW:0]    y_end;
    logic           vs_rise, hr_rise, hr_fall, pix_done, in_x, in_y, at_eol, at_ely;
    logic           emit, eof_now, accept;
    logic [3*DW-1:0] pix_data;

    logic             valid_q, sof_q, eol_q, eof_q;
    logic [3*DW-1:0]  data_q;

    assign bus.o_valid = valid_q;
    assign bus.o_sof   = sof_q;
    assign bus.o_eol   = eol_q;
    assign bus.o_eof   = eof_q;
    assign bus.o_data  = data_q;

    assign vs_rise = vs_r & ~vs_d;
    assign hr_rise = hr_r & ~hr_d;
    assign hr_fall = ~hr_r & hr_d;

    // The first byte of a line always starts a fresh pixel at column 0.
    assign ph_eff  = hr_rise ? 2'd0 : ph;
    assign x_eff   = hr_rise ? '0 : x;
    assign last_ph = (fmt_l == 2'd1) ? 2'd1 : (fmt_l == 2'd2) ? 2'd2 : 2'd0;
    assign pix_done = hr_r && (ph_eff == last_ph);

    assign x_end  = {1'b0, xs_l} + {1'b0, xl_l};
    assign y_end  = {1'b0, ys_l} + {1'b0, yl_l};
    assign in_x   = (x_eff >= xs_l) && ({1'b0, x_eff} < x_end);
    assign in_y   = (y >= ys_l) && ({1'b0, y} < y_end);
    assign at_eol = ({1'b0, x_eff} + {{XW{1'b0}}, 1'b1}) == x_end;
    assign at_ely = ({1'b0, y} + {{YW{1'b0}}, 1'b1}) == y_end;

    assign emit    = (state == CAPTURE) && pix_done && in_x && in_y;
    assign eof_now = emit && at_eol && at_ely;
    assign accept  = vs_rise && (state != IDLE) && en && (dcnt == 4'd0);

    always_comb begin
        pix_data = '0;
        case (fmt_l)
            2'd1:    pix_data = {{DW{1'b0}}, b0, dat_r};
            2'd2:    pix_data = {b0, b1, dat_r};
            default: pix_data = {{(2*DW){1'b0}}, dat_r};
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (vs_rise) begin
            if (state == IDLE)
                state_nxt = SYNC;
            else if (en && dcnt == 4'd0)
                state_nxt = CAPTURE;
            else
                state_nxt = DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_r <= 1'b0; vs_d <= 1'b0; hr_r <= 1'b0; hr_d <= 1'b0;
            dat_r <= '0; b0 <= '0; b1 <= '0;
            fmt_l <= '0; xs_l <= '0; xl_l <= '0; ys_l <= '0; yl_l <= '0;
            ph <= '0; x <= '0; y <= '0; dcnt <= '0;
            sof_pend <= 1'b0; done <= 1'b0;
            valid_q <= 1'b0; sof_q <= 1'b0; eol_q <= 1'b0; eof_q <= 1'b0;
            data_q <= '0; frame_cnt <= '0; o_err <= '0;
        end else begin
            vs_r  <= bus.cam_vsync;
            vs_d  <= vs_r;
            hr_r  <= bus.cam_href;
            hr_d  <= hr_r;
            dat_r <= bus.cam_data;

            if (hr_r) begin
                ph <= pix_done ? 2'd0 : ph_eff + 2'd1;
                x  <= pix_done ? x_eff + {{(XW-1){1'b0}}, 1'b1} : x_eff;
                if (ph_eff == 2'd0) b0 <= dat_r;
                if (ph_eff == 2'd1) b1 <= dat_r;
            end

            if (vs_rise)
                y <= '0;
            else if (hr_fall)
                y <= y + {{(YW-1){1'b0}}, 1'b1};

            valid_q <= emit;
            sof_q   <= emit && sof_pend;
            eol_q   <= emit && at_eol;
            eof_q   <= eof_now;
            data_q  <= emit ? pix_data : '0;
            if (emit)    sof_pend  <= 1'b0;
            if (eof_now) begin
                done      <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
            end

            o_err[0] <= (state == CAPTURE) && hr_fall && (ph != 2'd0);
            // A frame whose eof completes on this very cycle is not short.
            o_err[1] <= vs_rise && (state == CAPTURE) && !done && !eof_now;

            // The new frame's settings override the updates above for the old frame.
            if (vs_rise && state != IDLE) begin
                fmt_l <= fmt;
                xs_l  <= x_start;
                xl_l  <= x_len;
                ys_l  <= y_start;
                yl_l  <= y_len;
                if (accept) begin
                    dcnt     <= skip;
                    sof_pend <= 1'b1;
                    done     <= 1'b0;
                end else if (dcnt != 4'd0) begin
                    dcnt <= dcnt - 4'd1;
                end
            end
        end
    end
endmodule
